// File: rtl/imm_split_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_split_encoder_pkg
// Shared constants and encodings for the 32-bit constant to 16-bit immediate
// beat encoder. It holds the data and immediate widths, the out_kind beat
// encodings seen by the instruction emitter, and the encoder state encoding.
// -----------------------------------------------------------------------------
package imm_split_encoder_pkg;

   localparam int DATA_W = 32;
   localparam int IMM_W  = DATA_W / 2;

   // Beat kinds as presented on out_kind; 2'b11 is never produced.
   typedef enum logic [1:0] {
      KIND_SINGLE = 2'b00,   // addi-form, consumer sign-extends
      KIND_HI     = 2'b01,   // lui-form, upper half
      KIND_LO     = 2'b10    // ori-form, lower half, consumer zero-extends
   } kind_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SINGLE  = 3'd1,
      ST_HI_ONLY = 3'd2,
      ST_HI      = 3'd3,
      ST_LO      = 3'd4
   } state_e;

endpackage

// File: rtl/imm_split_encoder_fit.sv
// -----------------------------------------------------------------------------
// imm_fit_check
// Combinational classifier for a 32-bit constant.
//   value_i   : constant to classify
//   fits_o    : constant survives 16-bit sign extension unchanged
//   lo_zero_o : lower immediate half is zero (no LO beat needed)
// -----------------------------------------------------------------------------
module imm_fit_check
   import imm_split_encoder_pkg::*;
(
   input  logic [DATA_W-1:0] value_i,
   output logic              fits_o,
   output logic              lo_zero_o
);

   // Bits [31:15] must all equal the sign bit of the low half for the
   // value to be representable as a sign-extended 16-bit immediate.
   assign fits_o    = (&value_i[DATA_W-1:IMM_W-1]) | ~(|value_i[DATA_W-1:IMM_W-1]);
   assign lo_zero_o = ~(|value_i[IMM_W-1:0]);

endmodule

// File: rtl/imm_split_encoder.sv
// -----------------------------------------------------------------------------
// imm_split_encoder
// Encodes a 32-bit constant as one SINGLE beat (when it fits a sign-extended
// 16-bit immediate) or as a HI beat followed, if the lower half is non-zero,
// by a LO beat. Valid/ready on both sides, one cycle latency, no bubble
// between consecutive constants.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data        : constant input handshake
//   out_valid/out_ready              : beat output handshake
//   out_imm, out_kind, out_last      : beat immediate, kind, last-of-constant
// -----------------------------------------------------------------------------
module imm_split_encoder #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IMM_W-1:0]  out_imm,
   output logic [1:0]        out_kind,
   output logic              out_last
);

   import imm_split_encoder_pkg::*;

   state_e             state_q, state_d;
   logic [IMM_W-1:0]   imm_q, imm_d;
   logic [1:0]         kind_q, kind_d;
   logic               last_q, last_d;
   logic [IMM_W-1:0]   hold_q, hold_d;

   logic fits, lo_zero;
   logic accept, fire;

   imm_fit_check u_fit (
      .value_i   (in_data),
      .fits_o    (fits),
      .lo_zero_o (lo_zero)
   );

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   // State and beat registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         imm_q   <= '0;
         kind_q  <= KIND_SINGLE;
         last_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         imm_q   <= imm_d;
         kind_q  <= kind_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state and next-beat decode
   always_comb begin
      state_d = state_q;
      imm_d   = imm_q;
      kind_d  = kind_q;
      last_d  = last_q;
      hold_d  = hold_q;
      if (state_q == ST_HI && fire) begin
         state_d = ST_LO;
         imm_d   = hold_q;
         kind_d  = KIND_LO;
         last_d  = 1'b1;
      end else if (accept) begin
         // Reached from IDLE or on the handshake of a last beat.
         if (fits) begin
            state_d = ST_SINGLE;
            imm_d   = in_data[IMM_W-1:0];
            kind_d  = KIND_SINGLE;
            last_d  = 1'b1;
         end else if (lo_zero) begin
            state_d = ST_HI_ONLY;
            imm_d   = in_data[DATA_W-1:IMM_W];
            kind_d  = KIND_HI;
            last_d  = 1'b1;
         end else begin
            state_d = ST_HI;
            imm_d   = in_data[DATA_W-1:IMM_W];
            kind_d  = KIND_HI;
            last_d  = 1'b0;
            hold_d  = in_data[IMM_W-1:0];
         end
      end else if (fire) begin
         // Last beat taken with nothing new offered; beat fields hold.
         state_d = ST_IDLE;
      end
   end

   // Outputs
   always_comb begin
      out_valid = (state_q != ST_IDLE);
      // A new constant may enter on the same edge the final beat leaves.
      in_ready  = (state_q == ST_IDLE) | (out_valid & out_ready & last_q);
      out_imm   = imm_q;
      out_kind  = kind_q;
      out_last  = last_q;
   end

endmodule
